// File: rtl/conv_load_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// conv_load_ctrl_pkg
// Shared configuration for the convolution load controller: default geometry,
// the controller state encoding, a packed configuration record and small
// elaboration-time helpers.
// -----------------------------------------------------------------------------
package conv_load_ctrl_pkg;

    localparam int DEF_KERNEL_SIZE  = 3;  // kernel rows held in the overlap cache
    localparam int DEF_ROW_WORDS    = 4;  // feature-map words per row
    localparam int DEF_FMAP_HEIGHT  = 5;  // input feature-map rows
    localparam int DEF_KERNEL_WORDS = 9;  // weight words per run

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_W    = 3'd1,
        LOAD_ROWS = 3'd2,
        LAUNCH    = 3'd3,
        COMPUTE   = 3'd4,
        FINISH    = 3'd5
    } state_e;

    typedef struct packed {
        int unsigned kernel_size;
        int unsigned row_words;
        int unsigned fmap_height;
        int unsigned kernel_words;
    } config_t;

    // Bundle the geometry parameters into one record.
    function automatic config_t make_config(input int ks, input int rw,
                                            input int fh, input int kw);
        config_t c;
        c.kernel_size  = int'(ks);
        c.row_words    = int'(rw);
        c.fmap_height  = int'(fh);
        c.kernel_words = int'(kw);
        return c;
    endfunction

    // Counter width that never collapses to zero bits for a range of one.
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_load_addr_gen.sv
// -----------------------------------------------------------------------------
// conv_load_addr_gen
// Column/slot counters for the circular overlap-cache row buffer and the
// resulting cache write address (slot*ROW_WORDS + col).
//   clk, arst_n : clock, asynchronous active-low reset
//   clr         : synchronous clear of col and slot
//   adv         : one word written this cycle, advance col (and slot on wrap)
//   row_done    : the word written this cycle completes a row
//   cache_addr  : write address for the current word
// -----------------------------------------------------------------------------
module conv_load_addr_gen
    import conv_load_ctrl_pkg::*;
#(
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int ROW_WORDS   = DEF_ROW_WORDS
)(
    input  logic                                    clk,
    input  logic                                    arst_n,
    input  logic                                    clr,
    input  logic                                    adv,
    output logic                                    row_done,
    output logic [$clog2(KERNEL_SIZE*ROW_WORDS)-1:0] cache_addr
);

    localparam int COL_W  = safe_clog2(ROW_WORDS);
    localparam int SLOT_W = safe_clog2(KERNEL_SIZE);
    localparam int CA_W   = $clog2(KERNEL_SIZE*ROW_WORDS);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(ROW_WORDS-1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(KERNEL_SIZE-1);

    logic [COL_W-1:0]  col_q, col_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              col_last_s;

    // Next-state logic for the column and circular slot counters.
    always_comb begin
        col_d      = col_q;
        slot_d     = slot_q;
        col_last_s = (col_q == COL_LAST);
        row_done   = adv && col_last_s;
        if (clr) begin
            col_d  = '0;
            slot_d = '0;
        end else if (adv) begin
            if (col_last_s) begin
                col_d = '0;
                // Slot wraps so the oldest row is overwritten by the next one.
                if (slot_q == SLOT_LAST) begin
                    slot_d = '0;
                end else begin
                    slot_d = slot_q + SLOT_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end else begin
            col_d  = col_q;
            slot_d = slot_q;
        end
    end

    // Column and slot registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            col_q  <= '0;
            slot_q <= '0;
        end else begin
            col_q  <= col_d;
            slot_q <= slot_d;
        end
    end

    // Cache address is a pure function of the registered counters.
    always_comb begin
        cache_addr = CA_W'(int'(slot_q) * ROW_WORDS + int'(col_q));
    end

endmodule

// File: rtl/conv_load_ctrl.sv
// -----------------------------------------------------------------------------
// conv_load_ctrl
// Sequences one convolution run: load KERNEL_WORDS weights, fill the overlap
// cache with KERNEL_SIZE rows, launch the datapath, then for every further
// output row load one new row (reusing the other cached rows) and relaunch.
//   clk, arst_n                 : clock, asynchronous active-low reset
//   start / running / done      : run request, run-active level, end pulse
//   b_valid / b_ready           : weight word handshake (LOAD_W only)
//   int_mem_we / int_mem_addr   : weight memory write
//   a_valid / a_ready           : feature-map word handshake (LOAD_ROWS only)
//   overlap_cache_we/cache_addr : overlap cache write
//   data_ready                  : one-cycle compute launch
//   fsm_done                    : datapath finished the current output row
//   out_row                     : output row being computed
// -----------------------------------------------------------------------------
module conv_load_ctrl
    import conv_load_ctrl_pkg::*;
#(
    parameter int KERNEL_SIZE  = DEF_KERNEL_SIZE,
    parameter int ROW_WORDS    = DEF_ROW_WORDS,
    parameter int FMAP_HEIGHT  = DEF_FMAP_HEIGHT,
    parameter int KERNEL_WORDS = DEF_KERNEL_WORDS
)(
    input  logic                                     clk,
    input  logic                                     arst_n,
    input  logic                                     start,
    output logic                                     running,
    output logic                                     done,
    input  logic                                     a_valid,
    output logic                                     a_ready,
    input  logic                                     b_valid,
    output logic                                     b_ready,
    output logic                                     int_mem_we,
    output logic [$clog2(KERNEL_WORDS)-1:0]          int_mem_addr,
    output logic                                     overlap_cache_we,
    output logic [$clog2(KERNEL_SIZE*ROW_WORDS)-1:0] cache_addr,
    output logic                                     data_ready,
    input  logic                                     fsm_done,
    output logic [$clog2(FMAP_HEIGHT)-1:0]           out_row
);

    localparam config_t CFG = make_config(KERNEL_SIZE, ROW_WORDS,
                                          FMAP_HEIGHT, KERNEL_WORDS);
    localparam int WA_W = $clog2(KERNEL_WORDS);
    localparam int OR_W = $clog2(FMAP_HEIGHT);
    localparam int RL_W = $clog2(KERNEL_SIZE + 1);
    localparam logic [WA_W-1:0] W_LAST   = WA_W'(CFG.kernel_words - 1);
    localparam logic [OR_W-1:0] ROW_LAST = OR_W'(CFG.fmap_height - CFG.kernel_size);
    localparam logic [RL_W-1:0] RL_FULL  = RL_W'(CFG.kernel_size);
    localparam logic [RL_W-1:0] RL_ONE   = RL_W'(1);

    state_e          state_q, state_d;
    logic [WA_W-1:0] w_cnt_q, w_cnt_d;
    logic [RL_W-1:0] rows_left_q, rows_left_d;
    logic [OR_W-1:0] out_row_q, out_row_d;
    logic            running_q, running_d;
    logic            done_q, done_d;
    logic            data_ready_q, data_ready_d;
    logic            a_ready_q, a_ready_d;
    logic            b_ready_q, b_ready_d;

    logic            w_fire_s;
    logic            a_fire_s;
    logic            row_done_s;
    logic            addr_clr_s;

    // Handshakes only fire on the channel whose ready is up in this state.
    always_comb begin
        w_fire_s = b_valid && b_ready_q;
        a_fire_s = a_valid && a_ready_q;
    end

    conv_load_addr_gen #(
        .KERNEL_SIZE (KERNEL_SIZE),
        .ROW_WORDS   (int'(CFG.row_words))
    ) u_addr_gen (
        .clk        (clk),
        .arst_n     (arst_n),
        .clr        (addr_clr_s),
        .adv        (a_fire_s),
        .row_done   (row_done_s),
        .cache_addr (cache_addr)
    );

    // Next-state, counter and registered-output decode for the run FSM.
    always_comb begin
        state_d     = state_q;
        w_cnt_d     = w_cnt_q;
        rows_left_d = rows_left_q;
        out_row_d   = out_row_q;
        addr_clr_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = LOAD_W;
                    w_cnt_d     = '0;
                    rows_left_d = '0;
                    out_row_d   = '0;
                    addr_clr_s  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD_W: begin
                if (w_fire_s) begin
                    if (w_cnt_q == W_LAST) begin
                        w_cnt_d     = '0;
                        rows_left_d = RL_FULL;
                        state_d     = LOAD_ROWS;
                    end else begin
                        w_cnt_d = w_cnt_q + WA_W'(1);
                    end
                end else begin
                    w_cnt_d = w_cnt_q;
                end
            end
            LOAD_ROWS: begin
                if (row_done_s) begin
                    if (rows_left_q == RL_ONE) begin
                        rows_left_d = '0;
                        state_d     = LAUNCH;
                    end else begin
                        rows_left_d = rows_left_q - RL_ONE;
                    end
                end else begin
                    rows_left_d = rows_left_q;
                end
            end
            LAUNCH: begin
                // fsm_done is not looked at here, so a stale completion
                // coinciding with the launch cannot finish the row.
                state_d = COMPUTE;
            end
            COMPUTE: begin
                if (fsm_done) begin
                    if (out_row_q == ROW_LAST) begin
                        state_d = FINISH;
                    end else begin
                        // Later tiles reuse KERNEL_SIZE-1 cached rows.
                        out_row_d   = out_row_q + OR_W'(1);
                        rows_left_d = RL_ONE;
                        state_d     = LOAD_ROWS;
                    end
                end else begin
                    state_d = COMPUTE;
                end
            end
            FINISH: begin
                state_d     = IDLE;
                w_cnt_d     = '0;
                rows_left_d = '0;
                out_row_d   = '0;
                addr_clr_s  = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                w_cnt_d     = '0;
                rows_left_d = '0;
                out_row_d   = '0;
                addr_clr_s  = 1'b1;
            end
        endcase

        // Status outputs are decoded from the next state so they register
        // cleanly and line up with the state they describe.
        running_d    = (state_d != IDLE);
        done_d       = (state_d == FINISH);
        data_ready_d = (state_d == LAUNCH);
        a_ready_d    = (state_d == LOAD_ROWS);
        b_ready_d    = (state_d == LOAD_W);
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= IDLE;
            w_cnt_q      <= '0;
            rows_left_q  <= '0;
            out_row_q    <= '0;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            data_ready_q <= 1'b0;
            a_ready_q    <= 1'b0;
            b_ready_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            w_cnt_q      <= w_cnt_d;
            rows_left_q  <= rows_left_d;
            out_row_q    <= out_row_d;
            running_q    <= running_d;
            done_q       <= done_d;
            data_ready_q <= data_ready_d;
            a_ready_q    <= a_ready_d;
            b_ready_q    <= b_ready_d;
        end
    end

    // Output mapping; write enables follow the accepting handshake in-cycle.
    always_comb begin
        running          = running_q;
        done             = done_q;
        data_ready       = data_ready_q;
        a_ready          = a_ready_q;
        b_ready          = b_ready_q;
        int_mem_we       = w_fire_s;
        int_mem_addr     = w_cnt_q;
        overlap_cache_we = a_fire_s;
        out_row          = out_row_q;
    end

endmodule

// File: tb/tb_conv_load_ctrl.sv
`timescale 1ns/1ps
module tb_conv_load_ctrl;

    localparam int KS   = 3;
    localparam int RW   = 4;
    localparam int FH   = 5;
    localparam int KW   = 9;
    localparam int WA_W = $clog2(KW);
    localparam int CA_W = $clog2(KS*RW);
    localparam int OR_W = $clog2(FH);

    logic            clk = 1'b0;
    logic            arst_n = 1'b0;
    logic            start = 1'b0;
    logic            a_valid = 1'b0;
    logic            b_valid = 1'b0;
    logic            fsm_done = 1'b0;
    logic            running, done, a_ready, b_ready;
    logic            int_mem_we, overlap_cache_we, data_ready;
    logic [WA_W-1:0] int_mem_addr;
    logic [CA_W-1:0] cache_addr;
    logic [OR_W-1:0] out_row;

    always #5 clk = ~clk;

    conv_load_ctrl #(
        .KERNEL_SIZE (KS),
        .ROW_WORDS   (RW),
        .FMAP_HEIGHT (FH),
        .KERNEL_WORDS(KW)
    ) dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .start            (start),
        .running          (running),
        .done             (done),
        .a_valid          (a_valid),
        .a_ready          (a_ready),
        .b_valid          (b_valid),
        .b_ready          (b_ready),
        .int_mem_we       (int_mem_we),
        .int_mem_addr     (int_mem_addr),
        .overlap_cache_we (overlap_cache_we),
        .cache_addr       (cache_addr),
        .data_ready       (data_ready),
        .fsm_done         (fsm_done),
        .out_row          (out_row)
    );

    typedef struct {
        string name;
        bit    b_tog;   // b_valid alternates 0/1
        bit    a_tog;   // a_valid alternates 1/0
        bit    coinc;   // fsm_done also driven during the launch cycle
        bit    stray;   // start + fsm_done pulsed while loading weights
        int    exp_w;
        int    exp_c;
        int    exp_dr;
    } run_t;

    run_t runs[4];

    int n_checks = 0;
    int n_fail   = 0;
    int w_q[$];
    int c_q[$];
    int r_q[$];
    int w_cnt, c_cnt, dr_cnt, done_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Output monitor / scoreboard consumer, sampled on the falling edge.
    always @(negedge clk) begin
        if (arst_n) begin
            if (int_mem_we) begin
                w_cnt++;
                check("w_valid_high", b_valid, 1);
                if (w_q.size() == 0) check("w_unexpected_write", int_mem_addr, 32'hFFFF);
                else check("w_addr", int_mem_addr, w_q.pop_front());
            end
            if (overlap_cache_we) begin
                c_cnt++;
                check("c_valid_high", a_valid, 1);
                if (c_q.size() == 0) check("c_unexpected_write", cache_addr, 32'hFFFF);
                else check("c_addr", cache_addr, c_q.pop_front());
            end
            if (a_ready && b_ready) check("ready_exclusive", 1, 0);
            if (data_ready) begin
                dr_cnt++;
                if (r_q.size() == 0) check("dr_unexpected", out_row, 32'hFFFF);
                else check("dr_out_row", out_row, r_q.pop_front());
            end
            if (done) done_cnt++;
        end
    end

    task automatic push_full_run();
        for (int i = 0; i < KW; i++) w_q.push_back(i);
        for (int i = 0; i < KS*RW; i++) c_q.push_back(i);
        // Each later tile overwrites the oldest slot: slot (t-1) mod KS.
        for (int t = 1; t <= FH-KS; t++)
            for (int i = 0; i < RW; i++) c_q.push_back(((t-1) % KS)*RW + i);
        for (int t = 0; t <= FH-KS; t++) r_q.push_back(t);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_running"},  running, 0);
        check({tag, "_done"},     done, 0);
        check({tag, "_a_ready"},  a_ready, 0);
        check({tag, "_b_ready"},  b_ready, 0);
        check({tag, "_mem_we"},   int_mem_we, 0);
        check({tag, "_mem_addr"}, int_mem_addr, 0);
        check({tag, "_cache_we"}, overlap_cache_we, 0);
        check({tag, "_cache_addr"}, cache_addr, 0);
        check({tag, "_data_ready"}, data_ready, 0);
        check({tag, "_out_row"},  out_row, 0);
    endtask

    task automatic do_run(input run_t r);
        int cyc;
        int since_launch;
        bit launched;
        w_cnt = 0; c_cnt = 0; dr_cnt = 0; done_cnt = 0;
        push_full_run();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({r.name, "_running_after_start"}, running, 1);
        check({r.name, "_b_ready_after_start"}, b_ready, 1);
        cyc = 0; launched = 1'b0; since_launch = 0;
        while (done_cnt == 0 && cyc < 400) begin
            b_valid  = r.b_tog ? ((cyc % 2) == 1) : 1'b1;
            a_valid  = r.a_tog ? ((cyc % 2) == 0) : 1'b1;
            fsm_done = 1'b0;
            start    = 1'b0;
            if (data_ready) begin
                launched     = 1'b1;
                since_launch = 0;
                fsm_done     = r.coinc;
            end else if (launched) begin
                since_launch++;
                if (since_launch == 2) begin
                    fsm_done = 1'b1;
                    launched = 1'b0;
                end
            end
            if (r.stray && b_ready && cyc == 3) begin
                start    = 1'b1;
                fsm_done = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        fsm_done = 1'b0;
        start    = 1'b0;
        check({r.name, "_done_seen"}, done_cnt, 1);
        check({r.name, "_running_dropped"}, running, 0);
        check({r.name, "_done_one_cycle"}, done, 0);
        check({r.name, "_weight_writes"}, w_cnt, r.exp_w);
        check({r.name, "_cache_writes"}, c_cnt, r.exp_c);
        check({r.name, "_launches"}, dr_cnt, r.exp_dr);
        check({r.name, "_sb_empty"}, w_q.size() + c_q.size() + r_q.size(), 0);
        // Valids stay high in IDLE: any write would hit an empty scoreboard.
        repeat (3) @(posedge clk);
        #1;
        check({r.name, "_idle_out_row"}, out_row, 0);
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    initial begin
        int cyc;
        bit launched;
        runs[0] = '{"cont",        1'b0, 1'b0, 1'b0, 1'b0, 9, 20, 3};
        runs[1] = '{"b_toggle",    1'b1, 1'b0, 1'b0, 1'b0, 9, 20, 3};
        runs[2] = '{"a_toggle",    1'b0, 1'b1, 1'b0, 1'b0, 9, 20, 3};
        runs[3] = '{"stray_coinc", 1'b0, 1'b0, 1'b1, 1'b1, 9, 20, 3};

        #3;
        check_all_zero("reset");
        @(negedge clk);
        arst_n = 1'b1;

        for (int i = 0; i < 4; i++) do_run(runs[i]);

        // Reset asserted during the second tile's row load.
        w_cnt = 0; c_cnt = 0; dr_cnt = 0; done_cnt = 0;
        push_full_run();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a_valid = 1'b1;
        b_valid = 1'b1;
        cyc = 0; launched = 1'b0;
        while (c_cnt < KS*RW + 2 && cyc < 200) begin
            fsm_done = 1'b0;
            if (data_ready) launched = 1'b1;
            else if (launched) begin
                fsm_done = 1'b1;
                launched = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        fsm_done = 1'b0;
        check("pre_rst_cache_writes", c_cnt, KS*RW + 2);
        check("pre_rst_out_row", out_row, 1);
        check("pre_rst_cache_addr", cache_addr, 2);
        check("pre_rst_a_ready", a_ready, 1);
        arst_n = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("held_reset");
        w_q.delete();
        c_q.delete();
        r_q.delete();
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        do_run(runs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
